// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// mux-select codes and the per-state control word.
package multicycle_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  function automatic imm_src_t imm_decode(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: return IMM_I;
      OP_SW:       return IMM_S;
      OP_BEQ:      return IMM_B;
      OP_JAL:      return IMM_J;
      default:     return IMM_I;
    endcase
  endfunction

  // Moore control word for a state; HALT and unused encodings get all-zero.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_SUB;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from the main FSM's ALUOp and the instruction funct fields.
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means subtract for R-type; addi shares funct3 000.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multi-cycle RV32I core. Defining ILLEGAL_TRAP_EN makes
// unknown opcodes park the FSM in HALT (left only by reset) and raise illegal.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_HALT;
`else
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_HALT:     state_next = S_HALT;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= state_next;
      ctrl  <= state_ctrl(state_next);
    end
  end

  // Reset holds FETCH selects but must suppress every write strobe immediately.
  assign pc_write   = ~reset & (ctrl.pc_update | (ctrl.branch & zero));
  assign ir_write   = ~reset & ctrl.ir_write;
  assign mem_write  = ~reset & ctrl.mem_write;
  assign reg_write  = ~reset & ctrl.reg_write;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign imm_src    = imm_decode(op);
  assign state_o    = STATE_W'(state);

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs are
// queued when an instruction is applied and popped as the DUT steps through it.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
    .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, memw, irw, regw, adr;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    return {state_o, pc_write, mem_write, ir_write, reg_write, adr_src,
            result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic logic [2:0] model_funct(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t model(input state_t s, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
    obs_t e;
    e = '0;
    e.st = s;
    case (o)
      7'b0000011, 7'b0010011: e.imm = 2'b00;
      7'b0100011:             e.imm = 2'b01;
      7'b1100011:             e.imm = 2'b10;
      7'b1101111:             e.imm = 2'b11;
      default:                e.imm = 2'b00;
    endcase
    case (s)
      S_FETCH:    begin e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.rs = 2'b10; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWRITE: begin e.adr = 1; e.memw = 1; end
      S_MEMWB:    begin e.rs = 2'b01; e.regw = 1; end
      S_EXECUTER: begin e.sa = 2'b10; e.sb = 2'b00; e.alu = model_funct(o, f3, f7); end
      S_EXECUTEI: begin e.sa = 2'b10; e.sb = 2'b01; e.alu = model_funct(o, f3, f7); end
      S_ALUWB:    e.regw = 1;
      S_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
      S_HALT:     e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic state_t model_next(input state_t s, input logic [6:0] o);
    case (s)
      S_FETCH: return S_DECODE;
      S_DECODE: begin
        if (o == 7'b0000011 || o == 7'b0100011) return S_MEMADR;
        if (o == 7'b0110011) return S_EXECUTER;
        if (o == 7'b0010011) return S_EXECUTEI;
        if (o == 7'b1101111) return S_JAL;
        if (o == 7'b1100011) return S_BEQ;
`ifdef ILLEGAL_TRAP_EN
        return S_HALT;
`else
        return S_FETCH;
`endif
      end
      S_MEMADR:  return (o == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: return S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: return S_ALUWB;
      S_HALT:    return S_HALT;
      default:   return S_FETCH;
    endcase
  endfunction

  // Called at a negedge with the DUT in FETCH; compares max_cycles cycles at most.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int max_cycles, input bit end_cycle);
    state_t s;
    int     n;
    obs_t   e;
    s = S_FETCH;
    n = 0;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    do begin
      exp_q.push_back(model(s, o, f3, f7, z));
      s = model_next(s, o);
      n++;
    end while (s != S_FETCH && n < max_cycles);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", name, i + 1), 32'(observe()), 32'(e));
    end
    if (end_cycle) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " state"}, 32'(state_o), 32'(S_FETCH));
    check({tag, " enables"}, 32'({pc_write, ir_write, mem_write, reg_write, illegal}), 32'd0);
    check({tag, " selects"}, 32'({adr_src, alu_src_a, alu_src_b, result_src}), 32'b0_00_10_10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset("por");
    @(negedge clk);
    reset = 1'b0;

    run_instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 8, 1'b1);
    run_instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 8, 1'b1);
    run_instr("add",     7'b0110011, 3'b000, 1'b0, 1'b0, 8, 1'b1);
    run_instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 8, 1'b1);
    run_instr("slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 8, 1'b1);
    run_instr("or",      7'b0110011, 3'b110, 1'b0, 1'b0, 8, 1'b1);
    run_instr("and",     7'b0110011, 3'b111, 1'b0, 1'b1, 8, 1'b1);
    run_instr("r_f3_001",7'b0110011, 3'b001, 1'b1, 1'b0, 8, 1'b1);
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 8, 1'b1);
    run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 8, 1'b1);
    run_instr("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 8, 1'b1);
    run_instr("andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 8, 1'b1);
    run_instr("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1, 8, 1'b1);
    run_instr("beq_z0",  7'b1100011, 3'b000, 1'b0, 1'b0, 8, 1'b1);
    run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b1, 8, 1'b1);

    // Abort a store while it is in MEMWRITE.
    run_instr("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, 1'b0);
    #1 reset = 1'b1;
    #1 check_reset("rst_async");
    @(posedge clk);
    #1 check_reset("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    run_instr("sw_after", 7'b0100011, 3'b010, 1'b0, 1'b0, 8, 1'b1);

`ifdef ILLEGAL_TRAP_EN
    run_instr("halt", 7'b1111111, 3'b000, 1'b0, 1'b1, 12, 1'b0);
    #1 reset = 1'b1;
    #1 check_reset("halt_rst");
    @(negedge clk);
    reset = 1'b0;
`else
    run_instr("nop_op", 7'b1111111, 3'b000, 1'b0, 1'b1, 8, 1'b1);
`endif
    run_instr("lw_end", 7'b0000011, 3'b010, 1'b0, 1'b0, 8, 1'b1);
    #2 check("final state", 32'(state_o), 32'(S_FETCH));
    check("queue empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multi-cycle RV32I core. Reuses the single ALU, unified memory and immediate extender across 3-5 cycles per instruction.
- A Moore main FSM sequences fetch, decode, execute, memory and writeback. Outputs drive mux selects and write enables, plus ImmSrc for the extender.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq, jal.

Parameters:
- STATE_W, 4, width of state encoding and of the state_o debug port.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag, valid in BEQ state
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register and OldPC enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register file write enable
- state_o  out  STATE_W  current state, for debug and the bench
- illegal  out  1  illegal-opcode indication

Behaviour:
- Reset:
  - Asynchronous. State goes to FETCH immediately.
  - While reset is high, pc_write, ir_write, mem_write and reg_write are forced 0. illegal = 0.
  - Other outputs take their FETCH values.
  - Reset mid-instruction abandons it with no partial write after reset asserts.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- State transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw/sw; EXECUTER for R; EXECUTEI for I; JAL for jal; BEQ for beq.
  - DECODE with any other opcode -> FETCH.
  - MEMADR -> MEMREAD for lw; MEMWRITE for sw.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI / JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- State outputs (unlisted enables = 0, unlisted selects = 00):
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ALUOp=add, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, ALUOp=add (branch target).
  - MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=add.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, ALUOp=funct.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, ALUOp=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, ALUOp=sub, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, ALUOp=add, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & zero). This is the only Mealy term.
- imm_src is decoded combinationally from op in every state:
  - 00 for lw/I, 01 for sw, 10 for beq, 11 for jal.
  - 00 for R and for unknown opcodes; never X.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp funct by funct3: 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and.
  - Other funct3 values -> add.
- Latency in cycles (FETCH inclusive): lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Unused state encodings -> FETCH on next edge.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - DECODE with an unknown opcode -> state HALT.
  - In HALT all enables are 0 and illegal=1. HALT is left only by reset.
- Undefined:
  - Unknown opcode -> FETCH, executed as a 2-cycle no-op.
  - No HALT state; illegal is tied 0.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants;
  - state encodings (4-bit, including HALT);
  - ImmSrc, ALUOp, ALUControl, ResultSrc, ALUSrcA and ALUSrcB codes.
- Sub-module alu_decoder, combinational: inputs ALUOp, funct3, op[5], funct7b5; output alu_control.
- Main FSM and output logic stay in multicycle_controller.

Test Plan:
- Reset pulse mid-MEMWRITE (sw) -> state_o=FETCH asynchronously; mem_write=0 during reset; no write after release.
- lw (op=0000011) from FETCH:
  - state_o sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - reg_write=1 only in cycle 5; imm_src=00 throughout.
- R sub (funct3=000, funct7b5=1):
  - alu_control=001 in EXECUTER, reg_write=1 in ALUWB.
  - Same with funct7b5=0 gives 000; addi with funct7b5=1 gives 000.
- beq with zero=1 -> pc_write=1 in BEQ, next state FETCH. With zero=0 -> pc_write=0; 3-cycle latency.
- jal (op=1101111) -> imm_src=11; JAL state has pc_write=1, alu_src_a=01, alu_src_b=10; then ALUWB with reg_write=1.
- op=1111111:
  - with ILLEGAL_TRAP_EN -> HALT, illegal=1, no enables for 10 cycles until reset.
  - without -> back to FETCH after DECODE.
